// File: rtl/expu_correction_arbiter.sv
// Round-robin front end for the shared EXPU mantissa-correction register stage.
// Tracks the in-flight tag next to the datapath register and buffers results in a small FIFO.
module expu_correction_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  MANT_W    = 7,
    parameter int  OUT_DEPTH = 2,
    localparam int TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*MANT_W-1:0] req_mant_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      corr_enable_o,
    output logic                      corr_clear_o,
    output logic [MANT_W-1:0]         corr_mant_o,
    input  logic [MANT_W-1:0]         corr_result_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MANT_W-1:0]         out_mant_o,
    output logic [TAG_W-1:0]          out_tag_o,
    output logic                      busy_o
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    logic [TAG_W-1:0]  r_rr_ptr;
    logic              r_s1_valid;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [MANT_W-1:0] r_fifo_mant [OUT_DEPTH];
    logic [TAG_W-1:0]  r_fifo_tag  [OUT_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [MANT_W-1:0] w_mant       [NUM_REQ];
    logic [TAG_W-1:0]  w_cand_idx   [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand_valid;
    logic              w_any;
    logic [TAG_W-1:0]  w_win;
    logic [TAG_W-1:0]  w_rr_next;
    logic              w_fifo_full;
    logic              w_out_valid;
    logic              w_pop;
    logic              w_drain;
    logic              w_can_issue;
    logic              w_grant;

    // Candidate gi is the requester gi positions after the round-robin pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [TAG_W:0] w_sum;
        assign w_mant[gi]       = req_mant_i[gi*MANT_W +: MANT_W];
        assign w_sum            = {1'b0, r_rr_ptr} + (TAG_W+1)'(gi);
        assign w_cand_idx[gi]   = (w_sum >= (TAG_W+1)'(NUM_REQ))
                                ? TAG_W'(w_sum - (TAG_W+1)'(NUM_REQ))
                                : w_sum[TAG_W-1:0];
        assign w_cand_valid[gi] = req_valid_i[w_cand_idx[gi]];
        assign req_ready_o[gi]  = w_grant & (w_win == TAG_W'(gi));
    end

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_valid[k]) begin
                w_any = 1'b1;
                w_win = w_cand_idx[k];
            end
        end
    end

    assign w_rr_next   = (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_fifo_full = (r_count == CNT_W'(OUT_DEPTH));
    assign w_out_valid = rst_ni & (r_count != '0);
    assign w_pop       = w_out_valid & out_ready_i;
    // A full FIFO still accepts the S1 result when its head leaves the same cycle.
    assign w_drain     = r_s1_valid & (~w_fifo_full | w_pop);
    assign w_can_issue = rst_ni & ~flush_i & (~r_s1_valid | w_drain);
    assign w_grant     = w_can_issue & w_any;

    assign corr_enable_o = w_grant;
    assign corr_clear_o  = ~rst_ni | flush_i;
    assign corr_mant_o   = w_mant[w_win];
    assign out_valid_o   = w_out_valid;
    assign out_mant_o    = r_fifo_mant[r_rd_ptr];
    assign out_tag_o     = r_fifo_tag[r_rd_ptr];
    assign busy_o        = rst_ni & (r_s1_valid | (r_count != '0));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_ni & ~flush_i & w_drain) begin
            r_fifo_mant[r_wr_ptr] <= corr_result_i;
            r_fifo_tag[r_wr_ptr]  <= r_s1_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_grant) begin
                r_s1_valid <= 1'b1;
                r_s1_tag   <= w_win;
                r_rr_ptr   <= w_rr_next;
            end else if (w_drain) begin
                r_s1_valid <= 1'b0;
            end
            if (w_drain) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_drain) - CNT_W'(w_pop);
        end
    end
endmodule

// File: tb/tb_expu_correction_arbiter.sv
// Directed bench for expu_correction_arbiter with a datapath register model and
// a grant-order scoreboard of expected results.
module tb_expu_correction_arbiter;
    localparam int N  = 4;
    localparam int W  = 7;
    localparam int D  = 2;
    localparam int TW = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic [N-1:0]    req_valid_i;
    logic [N*W-1:0]  req_mant_i;
    logic [N-1:0]    req_ready_o;
    logic            corr_enable_o;
    logic            corr_clear_o;
    logic [W-1:0]    corr_mant_o;
    logic [W-1:0]    corr_result_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [W-1:0]    out_mant_o;
    logic [TW-1:0]   out_tag_o;
    logic            busy_o;

    expu_correction_arbiter #(.NUM_REQ(N), .MANT_W(W), .OUT_DEPTH(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_mant_i(req_mant_i), .req_ready_o(req_ready_o),
        .corr_enable_o(corr_enable_o), .corr_clear_o(corr_clear_o), .corr_mant_o(corr_mant_o),
        .corr_result_i(corr_result_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_mant_o(out_mant_o), .out_tag_o(out_tag_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in correction function for the shared datapath (0 maps to 0).
    function automatic logic [W-1:0] fix(input logic [W-1:0] m);
        return m ^ (m >> 1);
    endfunction

    // Datapath register: single stage with clear and enable.
    logic [W-1:0] dp_reg = '0;
    always @(posedge clk_i) begin
        if (corr_clear_o)       dp_reg <= '0;
        else if (corr_enable_o) dp_reg <= fix(corr_mant_o);
    end
    assign corr_result_i = dp_reg;

    int total = 0;
    int bad = 0;
    int dut_grants = 0;
    int m_rr = 0;
    bit m_s1v = 0;
    int m_fcnt = 0;
    int sb_tag[$];
    logic [W-1:0] sb_mant[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [W-1:0] mant_of(input int i);
        logic [N*W-1:0] v;
        v = req_mant_i;
        return v[i*W +: W];
    endfunction

    // Checks one cycle against the model, then advances the model across the edge.
    task automatic cycle();
        bit rst, fl, ordy, ov, drain, can, any, grant, pop;
        int g;
        logic [N-1:0] exp_rdy;
        #3;
        rst  = !rst_ni;
        fl   = flush_i;
        ordy = out_ready_i;
        ov   = !rst && (m_fcnt != 0);
        drain = m_s1v && ((m_fcnt < D) || (m_fcnt == D && ov && ordy));
        can  = !rst && !fl && (!m_s1v || drain);
        any  = 0;
        g    = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (!any && req_valid_i[idx]) begin
                any = 1;
                g   = idx;
            end
        end
        grant   = can && any;
        exp_rdy = grant ? N'(1 << g) : '0;
        chk("ready", 32'(req_ready_o), 32'(exp_rdy));
        chk("enable", 32'(corr_enable_o), 32'(grant));
        chk("clear", 32'(corr_clear_o), 32'(rst || fl));
        chk("out_valid", 32'(out_valid_o), 32'(ov));
        chk("busy", 32'(busy_o), 32'(!rst && (m_s1v || m_fcnt != 0)));
        if (ov) begin
            chk("out_mant", 32'(out_mant_o), 32'(sb_mant[0]));
            chk("out_tag", 32'(out_tag_o), 32'(sb_tag[0]));
        end
        if (!rst && any) chk("corr_mant", 32'(corr_mant_o), 32'(mant_of(g)));
        if (req_ready_o != '0) dut_grants++;
        if (ov && ordy && !fl)
            $display("out tag=%0d mant=%02h", out_tag_o, out_mant_o);
        @(posedge clk_i);
        if (rst) begin
            m_rr = 0; m_s1v = 0; m_fcnt = 0;
            sb_tag.delete(); sb_mant.delete();
        end else if (fl) begin
            m_s1v = 0; m_fcnt = 0;
            sb_tag.delete(); sb_mant.delete();
        end else begin
            pop = ov && ordy;
            if (pop) begin
                void'(sb_tag.pop_front());
                void'(sb_mant.pop_front());
            end
            m_fcnt = m_fcnt + int'(drain) - int'(pop);
            if (grant) begin
                m_s1v = 1;
                sb_tag.push_back(g);
                sb_mant.push_back(fix(mant_of(g)));
                m_rr = (g + 1) % N;
            end else if (drain) begin
                m_s1v = 0;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int g0;

    initial begin
        rst_ni = 0; flush_i = 0; req_valid_i = '0; out_ready_i = 1;
        req_mant_i = {7'h3C, 7'h11, 7'h2A, 7'h00};
        run(3);                                   // reset held low
        rst_ni = 1;
        run(1);                                   // idle after release

        req_valid_i = 4'hF;                       // all requesters, full throughput
        run(10);
        req_valid_i = '0;
        run(4);

        req_mant_i = {7'h55, 7'h00, 7'h7F, 7'h12};
        req_valid_i = 4'b0100;                    // lone requester 2, mantissa 0
        run(1);
        req_valid_i = '0;
        run(3);
        req_valid_i = 4'hF;                       // pointer now at 3
        run(1);
        req_valid_i = '0;
        run(3);

        out_ready_i = 0;                          // backpressure
        req_valid_i = 4'hF;
        g0 = dut_grants;
        run(6);
        chk("bp_grants", 32'(dut_grants - g0), 32'(D + 1));
        out_ready_i = 1;
        run(8);
        req_valid_i = '0;
        run(4);

        out_ready_i = 0;                          // fill FIFO and S1, then flush
        req_valid_i = 4'hF;
        run(4);
        flush_i = 1; out_ready_i = 1;
        run(1);
        flush_i = 0;
        run(3);
        req_valid_i = '0;
        run(4);

        req_valid_i = 4'hF;                       // toggling downstream ready
        for (int i = 0; i < 14; i++) begin
            out_ready_i = i[0];
            req_mant_i = N*W'($urandom);
            run(1);
        end
        req_valid_i = '0; out_ready_i = 1;
        run(5);

        req_valid_i = 4'b1010;                    // reset mid-operation
        run(3);
        rst_ni = 0;
        run(1);
        rst_ni = 1;
        req_valid_i = '0;
        run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
